// File: rtl/ms_slave_port_arbiter.sv
// Two-input round-robin arbiter onto one master-slave output port.
// Ports: clk, rst (sync, active-high); s_in/s_in_sync and s_in2/s_in2_sync
// are the two sources; s_out/s_out_notify/s_out_src are the shared output;
// drop_cnt is a saturating count of samples overwritten before emission.
module ms_slave_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 1,
    parameter int DROP_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_in,
    input  logic              s_in_sync,
    input  logic [DATA_W-1:0] s_in2,
    input  logic              s_in2_sync,
    output logic [DATA_W-1:0] s_out,
    output logic              s_out_notify,
    output logic              s_out_src,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic {SELECT, GAP} state_t;

    localparam logic [3:0] GAP_LOAD =
        4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

    state_t            state;
    logic [3:0]        gap_cnt;
    logic [DATA_W-1:0] hold_a;
    logic [DATA_W-1:0] hold_b;
    logic              pend_a;
    logic              pend_b;
    logic              last_src;

    logic              grant_a;
    logic              grant_b;
    logic              drop_a;
    logic              drop_b;
    logic [1:0]        drops;
    logic [DROP_W:0]   drop_sum;
    logic [DROP_W-1:0] drop_next;

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (state == SELECT) begin
            // On a tie, the source that was not granted last wins.
            if (pend_a && (!pend_b || last_src)) begin
                grant_a = 1'b1;
            end else if (pend_b) begin
                grant_b = 1'b1;
            end
        end
        // A sync landing on a source being granted is a fresh capture,
        // not an overwrite: the held value leaves through the grant.
        drop_a    = s_in_sync & pend_a & ~grant_a;
        drop_b    = s_in2_sync & pend_b & ~grant_b;
        drops     = {1'b0, drop_a} + {1'b0, drop_b};
        drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(drops);
        drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_out        <= '0;
            s_out_notify <= 1'b0;
            s_out_src    <= 1'b0;
            drop_cnt     <= '0;
            hold_a       <= '0;
            hold_b       <= '0;
            pend_a       <= 1'b0;
            pend_b       <= 1'b0;
            last_src     <= 1'b1;
            state        <= SELECT;
            gap_cnt      <= 4'd0;
        end else begin
            s_out_notify <= grant_a | grant_b;
            if (grant_a) begin
                s_out     <= hold_a;
                s_out_src <= 1'b0;
                last_src  <= 1'b0;
            end else if (grant_b) begin
                s_out     <= hold_b;
                s_out_src <= 1'b1;
                last_src  <= 1'b1;
            end

            if (s_in_sync) begin
                hold_a <= s_in;
                pend_a <= 1'b1;
            end else if (grant_a) begin
                pend_a <= 1'b0;
            end

            if (s_in2_sync) begin
                hold_b <= s_in2;
                pend_b <= 1'b1;
            end else if (grant_b) begin
                pend_b <= 1'b0;
            end

            drop_cnt <= drop_next;

            unique case (state)
                SELECT: begin
                    if ((grant_a || grant_b) && GAP_CYCLES > 0) begin
                        state   <= GAP;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= SELECT;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms_slave_port_arbiter.sv
// Bench for ms_slave_port_arbiter: two instances (gap 1 / 16-bit drops,
// gap 3 / 4-bit drops) share stimulus and are checked against a model.
module tb_ms_slave_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_d;
    logic        a_s;
    logic [31:0] b_d;
    logic        b_s;

    logic [31:0] o0_out;
    logic        o0_ntf;
    logic        o0_src;
    logic [15:0] o0_drop;
    logic [31:0] o1_out;
    logic        o1_ntf;
    logic        o1_src;
    logic [3:0]  o1_drop;

    int checks = 0;
    int errors = 0;
    bit armed = 1'b0;

    always #5 clk = ~clk;

    ms_slave_port_arbiter #(.DATA_W(32), .GAP_CYCLES(1), .DROP_W(16)) u0 (
        .clk(clk), .rst(rst),
        .s_in(a_d), .s_in_sync(a_s), .s_in2(b_d), .s_in2_sync(b_s),
        .s_out(o0_out), .s_out_notify(o0_ntf), .s_out_src(o0_src),
        .drop_cnt(o0_drop)
    );

    ms_slave_port_arbiter #(.DATA_W(32), .GAP_CYCLES(3), .DROP_W(4)) u1 (
        .clk(clk), .rst(rst),
        .s_in(a_d), .s_in_sync(a_s), .s_in2(b_d), .s_in2_sync(b_s),
        .s_out(o1_out), .s_out_notify(o1_ntf), .s_out_src(o1_src),
        .drop_cnt(o1_drop)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: per instance, pending samples, a cooldown of idle
    // cycles after each emission, and a clamped overwrite tally.
    logic [31:0] m_ha[2], m_hb[2], m_out[2];
    bit          m_pa[2], m_pb[2], m_last[2], m_ntf[2], m_src[2];
    int          m_cool[2], m_drop[2];

    function automatic int gap_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int max_of(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit ga;
            bit gb;
            int d;
            ga = 0;
            gb = 0;
            d  = 0;
            if (rst) begin
                m_ha[k] = 0; m_hb[k] = 0; m_out[k] = 0;
                m_pa[k] = 0; m_pb[k] = 0; m_last[k] = 1;
                m_ntf[k] = 0; m_src[k] = 0;
                m_cool[k] = 0; m_drop[k] = 0;
            end else begin
                if (m_cool[k] == 0) begin
                    if (m_pa[k] && m_pb[k]) begin
                        ga = (m_last[k] == 1);
                        gb = !ga;
                    end else begin
                        ga = m_pa[k];
                        gb = m_pb[k];
                    end
                end else begin
                    m_cool[k]--;
                end
                if (a_s && m_pa[k] && !ga) d++;
                if (b_s && m_pb[k] && !gb) d++;
                m_ntf[k] = ga || gb;
                if (ga) begin
                    m_out[k] = m_ha[k]; m_src[k] = 0; m_last[k] = 0;
                    m_pa[k] = 0; m_cool[k] = gap_of(k);
                end
                if (gb) begin
                    m_out[k] = m_hb[k]; m_src[k] = 1; m_last[k] = 1;
                    m_pb[k] = 0; m_cool[k] = gap_of(k);
                end
                if (a_s) begin m_ha[k] = a_d; m_pa[k] = 1; end
                if (b_s) begin m_hb[k] = b_d; m_pb[k] = 1; end
                m_drop[k] = m_drop[k] + d;
                if (m_drop[k] > max_of(k)) m_drop[k] = max_of(k);
            end
        end
        #1;
        if (armed) begin
            chk("u0_out", o0_out, m_out[0]);
            chk("u0_notify", {31'b0, o0_ntf}, {31'b0, m_ntf[0]});
            chk("u0_src", {31'b0, o0_src}, {31'b0, m_src[0]});
            chk("u0_drop", {16'b0, o0_drop}, m_drop[0]);
            chk("u1_out", o1_out, m_out[1]);
            chk("u1_notify", {31'b0, o1_ntf}, {31'b0, m_ntf[1]});
            chk("u1_src", {31'b0, o1_src}, {31'b0, m_src[1]});
            chk("u1_drop", {28'b0, o1_drop}, m_drop[1]);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle();
        a_s = 0;
        b_s = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        rst = 0;
    endtask

    initial begin
        int pulses;
        rst = 1; a_d = 0; b_d = 0; a_s = 0; b_s = 0;
        cyc();
        armed = 1;
        chk("rst_out", o0_out, 32'h0);
        chk("rst_notify", {31'b0, o0_ntf}, 32'h0);
        chk("rst_drop", {16'b0, o0_drop}, 32'h0);
        cyc();
        rst = 0;
        cyc();

        // Single sample from A.
        a_d = 32'h11; a_s = 1;
        cyc();
        idle();
        cyc();
        chk("t1_out", o0_out, 32'h11);
        chk("t1_notify", {31'b0, o0_ntf}, 32'h1);
        chk("t1_src", {31'b0, o0_src}, 32'h0);
        chk("t1_model_out", m_out[0], 32'h11);
        cyc();
        chk("t1_notify_low", {31'b0, o0_ntf}, 32'h0);
        chk("t1_hold", o0_out, 32'h11);

        // Tie after reset: A first, B two cycles later.
        do_reset();
        a_d = 32'hA1; b_d = 32'hB1; a_s = 1; b_s = 1;
        cyc();
        idle();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            pulses += int'(o0_ntf);
            if (i == 0) begin
                chk("t2_first", o0_out, 32'hA1);
                chk("t2_first_src", {31'b0, o0_src}, 32'h0);
            end
            if (i == 2) begin
                chk("t2_second", o0_out, 32'hB1);
                chk("t2_second_src", {31'b0, o0_src}, 32'h1);
            end
        end
        chk("t2_pulses", pulses, 32'd2);

        // Sync A on the cycle A is granted.
        do_reset();
        a_d = 32'h51; a_s = 1;
        cyc();
        a_d = 32'h52; a_s = 1;
        cyc();
        idle();
        chk("t5_old", o0_out, 32'h51);
        cyc();
        cyc();
        chk("t5_new", o0_out, 32'h52);
        chk("t5_new_notify", {31'b0, o0_ntf}, 32'h1);
        chk("t5_drop", {16'b0, o0_drop}, 32'h0);

        // Reset while both pending and in the gap.
        do_reset();
        a_d = 32'h61; b_d = 32'h62; a_s = 1; b_s = 1;
        cyc();
        a_d = 32'h63; b_d = 32'h64;
        cyc();
        chk("t6_pre", o0_out, 32'h61);
        idle();
        rst = 1;
        cyc();
        rst = 0;
        chk("t6_out", o0_out, 32'h0);
        chk("t6_notify", {31'b0, o0_ntf}, 32'h0);
        chk("t6_drop", {16'b0, o0_drop}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            pulses += int'(o0_ntf) + int'(o1_ntf);
        end
        chk("t6_quiet", pulses, 32'd0);
        a_d = 32'h71; b_d = 32'h72; a_s = 1; b_s = 1;
        cyc();
        idle();
        cyc();
        chk("t6_tie", o0_out, 32'h71);
        chk("t6_tie_src", {31'b0, o0_src}, 32'h0);

        // Continuous A overwrite saturates the 4-bit counter.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            a_d = $urandom; a_s = 1;
            cyc();
        end
        idle();
        cyc();
        chk("t4_sat", {28'b0, o1_drop}, 32'd15);
        chk("t4_model_sat", m_drop[1], 32'd15);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            a_d = $urandom;
            b_d = $urandom;
            a_s = ($urandom_range(0, 9) < 4);
            b_s = ($urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 249) == 0);
            cyc();
        end
        idle();
        rst = 0;
        for (int i = 0; i < 8; i++) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
